// File: rtl/drc_dvp_tx_pkg.sv
// Shared types, default frame timings and helpers for the DVP transmitter.
// The optional test-pattern source is enabled by DVP_TX_TEST_PATTERN_EN (see drc_dvp_tx).
package drc_dvp_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        VSYNC  = 3'd1,
        VBP    = 3'd2,
        ACTIVE = 3'd3,
        VFP    = 3'd4
    } state_e;

    // Debug view of the frame FSM and pixel-clock strobes.
    typedef struct packed {
        state_e state;
        logic   fall_tick;
        logic   rise_tick;
    } dbg_t;

    localparam int VGA_H_ACT    = 640;
    localparam int VGA_H_BLANK  = 16;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 2;
    localparam int VGA_V_ACT    = 480;
    localparam int VGA_V_FP     = 2;

    localparam int QVGA_H_ACT   = 320;
    localparam int QVGA_H_BLANK = 16;
    localparam int QVGA_V_SYNC  = 2;
    localparam int QVGA_V_BP    = 2;
    localparam int QVGA_V_ACT   = 240;
    localparam int QVGA_V_FP    = 2;

    // Counter width for a counter running 0..n-1; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    // Colour-bar byte: bar index in the high nibble, its complement in the low nibble.
    function automatic logic [7:0] tp_byte(input logic [3:0] idx);
        return {idx, ~idx};
    endfunction

endpackage

// File: rtl/drc_pclk_gen.sv
// Free-running pixel-clock divider: pclk toggles every PCLK_DIV clk cycles,
// with single-cycle strobes on the cycles where pclk is about to fall or rise.
module drc_pclk_gen
    import drc_dvp_tx_pkg::*;
#(
    parameter int PCLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    output logic pclk,
    output logic fall_tick,
    output logic rise_tick
);

    localparam int DIV_W = cnt_w(PCLK_DIV);

    logic [DIV_W-1:0] div_cnt;
    logic             wrap;

    assign wrap = (div_cnt == DIV_W'(PCLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            pclk    <= 1'b0;
        end else if (wrap) begin
            div_cnt <= '0;
            pclk    <= ~pclk;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Strobes are high on the cycle whose closing edge flips the registered pclk.
    assign fall_tick = wrap & pclk;
    assign rise_tick = wrap & ~pclk;

endmodule

// File: rtl/drc_dvp_tx.sv
// DVP transmitter: serialises an upstream byte stream into VSYNC/HREF/data frames.
// Define DVP_TX_TEST_PATTERN_EN to add tp_sel_i and the internal 8-bar colour pattern.
module drc_dvp_tx
    import drc_dvp_tx_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int PCLK_DIV = 2,
    parameter int H_ACT    = VGA_H_ACT,
    parameter int H_BLANK  = VGA_H_BLANK,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter int V_ACT    = VGA_V_ACT,
    parameter int V_FP     = VGA_V_FP
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] pix_data_i,
    input  logic              pix_valid_i,
`ifdef DVP_TX_TEST_PATTERN_EN
    input  logic              tp_sel_i,
`endif
    output logic              pix_ready_o,
    output logic              dvp_pclk_o,
    output logic              dvp_vsync_o,
    output logic              dvp_href_o,
    output logic [DATA_W-1:0] dvp_d_o,
    output logic              frame_done_o,
    output logic              underflow_o,
    output dbg_t              dbg
);

    localparam int LINE_TICKS = H_ACT + H_BLANK;
    localparam int TICK_W     = cnt_w(LINE_TICKS);
    localparam int LINE_W     = cnt_w(max4(V_SYNC, V_BP, V_ACT, V_FP));
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(LINE_TICKS - 1);

    logic fall_tick;
    logic rise_tick;

    drc_pclk_gen #(.PCLK_DIV(PCLK_DIV)) u_pclk_gen (
        .clk       (clk),
        .rst       (rst),
        .pclk      (dvp_pclk_o),
        .fall_tick (fall_tick),
        .rise_tick (rise_tick)
    );

    // state/line_cnt/tick_cnt name the tick currently shown on the pins.
    state_e            state, nxt_state;
    logic [LINE_W-1:0] line_cnt, nxt_line, lines_last;
    logic [TICK_W-1:0] tick_cnt, nxt_tick;
    logic              frame_end;
    logic              nxt_href;
    logic              nxt_vsync;
    logic [DATA_W-1:0] nxt_d;
    logic              uf_set;
    logic              tp_active;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            line_cnt <= '0;
            tick_cnt <= '0;
        end else if (fall_tick) begin
            state    <= nxt_state;
            line_cnt <= nxt_line;
            tick_cnt <= nxt_tick;
        end
    end

    always_comb begin
        nxt_state  = state;
        nxt_line   = line_cnt;
        nxt_tick   = tick_cnt;
        frame_end  = 1'b0;
        lines_last = '0;
        case (state)
            VSYNC:   lines_last = LINE_W'(V_SYNC - 1);
            VBP:     lines_last = LINE_W'(V_BP - 1);
            ACTIVE:  lines_last = LINE_W'(V_ACT - 1);
            VFP:     lines_last = LINE_W'(V_FP - 1);
            default: lines_last = '0;
        endcase
        if (state == IDLE) begin
            if (en) nxt_state = VSYNC;
        end else if (tick_cnt != TICK_LAST) begin
            nxt_tick = tick_cnt + TICK_W'(1);
        end else begin
            nxt_tick = '0;
            if (line_cnt != lines_last) begin
                nxt_line = line_cnt + LINE_W'(1);
            end else begin
                nxt_line = '0;
                case (state)
                    VSYNC:  nxt_state = VBP;
                    VBP:    nxt_state = ACTIVE;
                    ACTIVE: nxt_state = VFP;
                    VFP: begin
                        frame_end = 1'b1;
                        nxt_state = en ? VSYNC : IDLE;
                    end
                    default: nxt_state = IDLE;
                endcase
            end
        end
    end

    // Upstream handshake: a byte is consumed on any cycle where pix_ready_o and
    // pix_valid_i are both high; pix_ready_o never waits on pix_valid_i and the
    // line timing never stalls, so a missing byte becomes a zero plus underflow.
`ifdef DVP_TX_TEST_PATTERN_EN
    logic       tp_sel_q;
    logic [3:0] tp_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            tp_sel_q <= 1'b0;
        end else if (fall_tick && nxt_state == VSYNC && state != VSYNC) begin
            tp_sel_q <= tp_sel_i;
        end
    end

    assign tp_active = tp_sel_q;
    assign tp_idx    = 4'((int'(nxt_tick) * 8) / H_ACT);
`else
    assign tp_active = 1'b0;
`endif

    always_comb begin
        nxt_vsync   = (nxt_state == VSYNC);
        nxt_href    = (nxt_state == ACTIVE) && (nxt_tick < TICK_W'(H_ACT));
        pix_ready_o = fall_tick && nxt_href && !tp_active;
        nxt_d       = '0;
        uf_set      = 1'b0;
        if (nxt_href) begin
            if (tp_active) begin
`ifdef DVP_TX_TEST_PATTERN_EN
                nxt_d = DATA_W'(tp_byte(tp_idx));
`endif
            end else if (pix_valid_i) begin
                nxt_d = pix_data_i;
            end else begin
                uf_set = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dvp_vsync_o  <= 1'b0;
            dvp_href_o   <= 1'b0;
            dvp_d_o      <= '0;
            frame_done_o <= 1'b0;
            underflow_o  <= 1'b0;
        end else begin
            frame_done_o <= fall_tick & frame_end;
            if (fall_tick) begin
                dvp_vsync_o <= nxt_vsync;
                dvp_href_o  <= nxt_href;
                dvp_d_o     <= nxt_d;
            end
            if (fall_tick & uf_set) underflow_o <= 1'b1;
        end
    end

    assign dbg = '{state: state, fall_tick: fall_tick, rise_tick: rise_tick};

endmodule

// File: tb/tb_drc_dvp_tx.sv
// Scoreboard bench for drc_dvp_tx with a small 6-tick x 5-line frame geometry.
module tb_drc_dvp_tx;
    import drc_dvp_tx_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] pix_data_i;
    logic       pix_valid_i;
    logic       pix_ready_o, dvp_pclk_o, dvp_vsync_o, dvp_href_o, frame_done_o, underflow_o;
    logic [7:0] dvp_d_o;
    dbg_t       dbg;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;
    int slot_cnt = 0;
    int drop_slot = -1;
    int ready_cnt = 0;
    logic [7:0] nxt_byte = 8'h10;
    logic [7:0] exp_q[$];
    int vs_rise_cyc[$], vs_fall_cyc[$], fd_cyc[$];

    drc_dvp_tx #(
        .DATA_W(8), .PCLK_DIV(2), .H_ACT(4), .H_BLANK(2),
        .V_SYNC(1), .V_BP(1), .V_ACT(2), .V_FP(1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .pix_data_i   (pix_data_i),
        .pix_valid_i  (pix_valid_i),
`ifdef DVP_TX_TEST_PATTERN_EN
        .tp_sel_i     (1'b0),
`endif
        .pix_ready_o  (pix_ready_o),
        .dvp_pclk_o   (dvp_pclk_o),
        .dvp_vsync_o  (dvp_vsync_o),
        .dvp_href_o   (dvp_href_o),
        .dvp_d_o      (dvp_d_o),
        .frame_done_o (frame_done_o),
        .underflow_o  (underflow_o),
        .dbg          (dbg)
    );

    // Clock / reset block
    always #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Driver: offers the next byte every cycle; valid drops only on the chosen slot.
    initial begin
        pix_valid_i = 1'b1;
        pix_data_i  = 8'h00;
        forever begin
            @(negedge clk);
            pix_valid_i = (slot_cnt != drop_slot);
            pix_data_i  = nxt_byte;
            if (pix_ready_o && !rst) begin
                slot_cnt++;
                if (pix_valid_i) nxt_byte++;
            end
        end
    end

    // Monitor: receiver-side sampling at pclk rise plus pin-phase and event logging.
    initial begin
        logic       prev_pclk, prev_vs, prev_rst, started;
        logic [9:0] prev_bus;
        int         last_rise;
        started   = 1'b0;
        last_rise = -1;
        prev_pclk = 1'b0;
        prev_vs   = 1'b0;
        prev_rst  = 1'b1;
        prev_bus  = '0;
        forever begin
            @(negedge clk);
            if (started && !rst && !prev_rst) begin
                if (!prev_pclk && dvp_pclk_o) begin
                    if (last_rise >= 0) check("pclk_period", cyc - last_rise, 4);
                    last_rise = cyc;
                    if (dvp_href_o) begin
                        if (exp_q.size() == 0) begin
                            n_total++;
                            $display("FAIL byte_extra: got 0x%0h, expected no byte", dvp_d_o);
                        end else begin
                            check("dvp_byte", dvp_d_o, exp_q.pop_front());
                        end
                    end
                end
                if ({dvp_vsync_o, dvp_href_o, dvp_d_o} != prev_bus)
                    check("change_at_pclk_fall", {31'd0, prev_pclk & ~dvp_pclk_o}, 1);
                if (dvp_vsync_o && !prev_vs) vs_rise_cyc.push_back(cyc);
                if (!dvp_vsync_o && prev_vs) vs_fall_cyc.push_back(cyc);
                if (frame_done_o) fd_cyc.push_back(cyc);
                if (pix_ready_o) ready_cnt++;
            end
            if (rst) last_rise = -1;
            prev_pclk = dvp_pclk_o;
            prev_vs   = dvp_vsync_o;
            prev_bus  = {dvp_vsync_o, dvp_href_o, dvp_d_o};
            prev_rst  = rst;
            started   = 1'b1;
        end
    end

`ifdef DVP_TX_TEST_PATTERN_EN
    logic       tp_en = 1'b0;
    logic       tp_ready, tp_pclk, tp_vs, tp_href, tp_fd, tp_uf;
    logic [7:0] tp_d;
    dbg_t       tp_dbg;
    int         tp_ready_cnt = 0;
    logic [7:0] tp_q[$];

    drc_dvp_tx #(
        .DATA_W(8), .PCLK_DIV(2), .H_ACT(8), .H_BLANK(2),
        .V_SYNC(1), .V_BP(1), .V_ACT(1), .V_FP(1)
    ) tp_dut (
        .clk          (clk),
        .rst          (rst),
        .en           (tp_en),
        .pix_data_i   (8'hAA),
        .pix_valid_i  (1'b0),
        .tp_sel_i     (1'b1),
        .pix_ready_o  (tp_ready),
        .dvp_pclk_o   (tp_pclk),
        .dvp_vsync_o  (tp_vs),
        .dvp_href_o   (tp_href),
        .dvp_d_o      (tp_d),
        .frame_done_o (tp_fd),
        .underflow_o  (tp_uf),
        .dbg          (tp_dbg)
    );

    initial begin
        logic prev_p;
        prev_p = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (tp_vs) tp_en = 1'b0;
                if (tp_ready) tp_ready_cnt++;
                if (!prev_p && tp_pclk && tp_href) begin
                    if (tp_q.size() == 0) begin
                        n_total++;
                        $display("FAIL tp_byte_extra: got 0x%0h, expected no byte", tp_d);
                    end else begin
                        check("tp_byte", tp_d, tp_q.pop_front());
                    end
                end
            end
            prev_p = tp_pclk;
        end
    end
`endif

    // Main directed sequence
    initial begin
        logic [7:0] frame12[16];
        int n, c0, lat, r0;
        frame12 = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17,
                    8'h18, 8'h19, 8'h00, 8'h1A, 8'h1B, 8'h1C, 8'h1D, 8'h1E};
        rst = 1'b1;
        en  = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_pclk", dvp_pclk_o, 0);
        check("rst_vsync", dvp_vsync_o, 0);
        check("rst_href", dvp_href_o, 0);
        check("rst_d", dvp_d_o, 0);
        check("rst_ready", pix_ready_o, 0);
        check("rst_frame_done", frame_done_o, 0);
        check("rst_underflow", underflow_o, 0);
        check("rst_state", dbg.state, IDLE);

        for (int i = 0; i < 16; i++) exp_q.push_back(frame12[i]);
        drop_slot = 10;
`ifdef DVP_TX_TEST_PATTERN_EN
        tp_q = '{8'h0F, 8'h1E, 8'h2D, 8'h3C, 8'h4B, 8'h5A, 8'h69, 8'h78};
        tp_en = 1'b1;
`endif
        rst = 1'b0;
        en  = 1'b1;

        n = 0;
        while (slot_cnt < 10 && n < 600) begin @(negedge clk); n++; end
        check("underflow_clear_before_drop", underflow_o, 0);
        while (slot_cnt < 12 && n < 600) begin @(negedge clk); n++; end
        check("reached_frame2_active", dbg.state, ACTIVE);
        en = 1'b0;

        n = 0;
        while (fd_cyc.size() < 2 && n < 600) begin @(negedge clk); n++; end
        @(negedge clk);
        check("frames_done_count", fd_cyc.size(), 2);
        check("idle_after_en_drop", dbg.state, IDLE);
        check("vsync_low_in_idle", dvp_vsync_o, 0);
        check("underflow_sticky", underflow_o, 1);
        check("all_bytes_seen", exp_q.size(), 0);
        if (vs_rise_cyc.size() >= 2 && vs_fall_cyc.size() >= 2 && fd_cyc.size() >= 2) begin
            check("vsync_width_f1", vs_fall_cyc[0] - vs_rise_cyc[0], 24);
            check("vsync_width_f2", vs_fall_cyc[1] - vs_rise_cyc[1], 24);
            check("frame_done_f1", fd_cyc[0] - vs_rise_cyc[0], 120);
            check("frame_done_f2", fd_cyc[1] - vs_rise_cyc[1], 120);
            check("back_to_back", vs_rise_cyc[1] - vs_rise_cyc[0], 120);
        end else begin
            check("frame_events_logged", vs_rise_cyc.size(), 2);
        end

        r0 = ready_cnt;
        repeat (20) @(negedge clk);
        check("stays_idle", dbg.state, IDLE);
        check("no_new_frame_when_en_low", vs_rise_cyc.size(), 2);
        check("no_ready_in_idle", ready_cnt - r0, 0);

        for (int i = 0; i < 8; i++) exp_q.push_back(8'h1F + 8'(i));
        c0 = cyc;
        en = 1'b1;
        n = 0;
        while (vs_rise_cyc.size() < 3 && n < 50) begin @(negedge clk); n++; end
        en = 1'b0;
        lat = (vs_rise_cyc.size() >= 3) ? vs_rise_cyc[2] - c0 : -1;
        check("restart_latency_in_1_to_4", {31'd0, (lat >= 1 && lat <= 4)}, 1);

        n = 0;
        while (slot_cnt < 18 && n < 300) begin @(negedge clk); n++; end
        repeat (2) @(negedge clk);
        check("mid_active_href", dvp_href_o, 1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_pclk", dvp_pclk_o, 0);
        check("midrst_vsync", dvp_vsync_o, 0);
        check("midrst_href", dvp_href_o, 0);
        check("midrst_d", dvp_d_o, 0);
        check("midrst_ready", pix_ready_o, 0);
        check("midrst_underflow", underflow_o, 0);
        check("midrst_state", dbg.state, IDLE);
        exp_q.delete();
        rst = 1'b0;
        r0 = ready_cnt;
        repeat (40) @(negedge clk);
        check("no_ready_after_rst", ready_cnt - r0, 0);
        check("idle_after_rst", dbg.state, IDLE);
        check("vsync_low_after_rst", dvp_vsync_o, 0);

`ifdef DVP_TX_TEST_PATTERN_EN
        check("tp_all_bytes_seen", tp_q.size(), 0);
        check("tp_ready_never", tp_ready_cnt, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
